// File: rtl/common_pkg.sv
// Shared types and defaults for the memory bus arbiter.
package common_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DMA  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } arb_owner_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYC = 16;

    // Access captured from the winning requester at grant time.
    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts memory wait cycles of the current transfer; tc flags the last allowed one.
module bus_timeout_counter #(
    parameter int unsigned TERMINAL = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)    cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 8'd1;
    end

    assign tc = (cnt == 8'(TERMINAL - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between a CPU and a DMA requester,
// with a per-transfer wait-state timeout.
module mem_bus_arbiter
    import common_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [15:0] i_cpu_addr,
    input  logic [15:0] i_cpu_wdata,
    output logic [15:0] o_cpu_rdata,
    output logic        o_cpu_ack,
    input  logic        i_dma_req,
    input  logic        i_dma_we,
    input  logic [15:0] i_dma_addr,
    input  logic [15:0] i_dma_wdata,
    output logic [15:0] o_dma_rdata,
    output logic        o_dma_ack,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_we,
    output logic        o_mem_re,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ready,
    output arb_owner_e  o_owner,
    output logic        o_err
);

    arb_state_e  state, state_nxt;
    logic        last_dma;
    bus_req_t    acc_q;
    logic        grant_cpu, grant_dma;
    logic        busy, tc, tmo, done;
    logic [15:0] done_rdata;

    bus_timeout_counter #(.TERMINAL(TIMEOUT_CYC)) u_tmo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .clr   (grant_cpu | grant_dma),
        .en    (busy & ~i_mem_ready),
        .tc    (tc)
    );

    assign busy       = (state != ARB_IDLE);
    // Ready wins over timeout when both land on the same cycle.
    assign tmo        = busy & ~i_mem_ready & tc;
    assign done       = busy & (i_mem_ready | tmo);
    assign done_rdata = i_mem_ready ? i_mem_rdata : 16'hFFFF;

    always_comb begin
        state_nxt   = state;
        grant_cpu   = 1'b0;
        grant_dma   = 1'b0;
        o_owner     = OWN_NONE;
        o_cpu_ack   = 1'b0;
        o_dma_ack   = 1'b0;
        o_cpu_rdata = 16'h0000;
        o_dma_rdata = 16'h0000;
        case (state)
            ARB_IDLE: begin
                if (i_cpu_req && (!i_dma_req || last_dma)) begin
                    grant_cpu = 1'b1;
                    state_nxt = ARB_CPU;
                end else if (i_dma_req) begin
                    grant_dma = 1'b1;
                    state_nxt = ARB_DMA;
                end
            end
            ARB_CPU: begin
                o_owner = OWN_CPU;
                if (done) begin
                    o_cpu_ack   = 1'b1;
                    o_cpu_rdata = done_rdata;
                    state_nxt   = ARB_IDLE;
                end
            end
            ARB_DMA: begin
                o_owner = OWN_DMA;
                if (done) begin
                    o_dma_ack   = 1'b1;
                    o_dma_rdata = done_rdata;
                    state_nxt   = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ARB_IDLE;
            last_dma <= 1'b1;
            acc_q    <= '0;
        end else begin
            state <= state_nxt;
            if (grant_cpu) begin
                acc_q    <= '{we: i_cpu_we, addr: i_cpu_addr, wdata: i_cpu_wdata};
                last_dma <= 1'b0;
            end else if (grant_dma) begin
                acc_q    <= '{we: i_dma_we, addr: i_dma_addr, wdata: i_dma_wdata};
                last_dma <= 1'b1;
            end
        end
    end

    assign o_mem_addr  = acc_q.addr;
    assign o_mem_wdata = acc_q.wdata;
    assign o_mem_re    = busy & ~tmo & ~acc_q.we;
    assign o_mem_we    = busy & ~tmo & acc_q.we;
    assign o_err       = tmo;

endmodule
